// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: transforms a 128-bit state a few columns per cycle,
// with a valid/ready handshake on both sides and a bypass for the final decrypt round.
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int unsigned SW   = 128;
  localparam int unsigned CW   = 32;
  localparam int unsigned NCOL = 4;
  localparam int unsigned CNTW = 2;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_work;
  logic [CNTW-1:0]   r_col;
  logic              r_bypass;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [SW-1:0]     w_work_nxt;
  logic              w_last;
  logic [CW-1:0]     w_cols      [NCOL];
  logic [CW-1:0]     w_next_cols [NCOL];

  // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; 09/0B/0D/0E built from the x2/x4/x8 xtime chain.
  function automatic logic [CW-1:0] inv_mix_col(input logic [CW-1:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[CW-1-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Replace the columns selected by the counter with their transformed value.
  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      w_cols[c] = r_work[SW-1-CW*c -: CW];
    end
    for (int c = 0; c < NCOL; c++) begin
      w_next_cols[c] = w_cols[c];
    end
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_next_cols[r_col + CNTW'(k)] = inv_mix_col(w_cols[r_col + CNTW'(k)]);
    end
    w_work_nxt = {w_next_cols[0], w_next_cols[1], w_next_cols[2], w_next_cols[3]};
    w_last     = (r_col + CNTW'(COLS_PER_CYCLE - 1)) == CNTW'(NCOL - 1);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = bypass ? S_DONE : S_BUSY;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Working register doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_col    <= '0;
      r_bypass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work   <= state_in;
            r_bypass <= bypass;
            r_col    <= '0;
          end
        end
        S_BUSY: begin
          if (!r_bypass) begin
            r_work <= w_work_nxt;
            r_col  <= r_col + CNTW'(COLS_PER_CYCLE);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_work;

endmodule
